// File: rtl/mux_arb_nch.sv
// N-channel registered multiplexer with built-in valid/ready arbitration.
// Round-robin (mode=0) or fixed lowest-index priority (mode=1) selects which channel loads the output register.
module mux_arb_nch #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SW:0]   NUM_CH  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N-1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic [WIDTH-1:0] word [N];
  logic [SW-1:0]    start;
  logic [SW:0]      idx;
  logic [SW-1:0]    win;
  logic             found;
  logic             load_en;
  logic             accept;
  logic [N-1:0]     grant;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign word[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Circular search from the start index; one extra bit on idx absorbs the wrap.
  always_comb begin
    start = mode ? '0 : ptr_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (SW+1)'(k);
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!found && in_valid[idx[SW-1:0]]) begin
        found = 1'b1;
        win   = idx[SW-1:0];
      end
    end
  end

  assign load_en  = !out_valid_q || out_ready;
  assign accept   = load_en && found;
  assign grant    = found ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
  assign in_ready = load_en ? grant : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = word[win];
        out_sel_d  = win;
      end
    end
    // The pointer only moves past a channel that actually handed over a word.
    if (accept && !mode) begin
      ptr_d = (win == LAST_CH) ? '0 : win + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
